// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM/grant encoding and requester indices for the SRAM port arbiter
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, WR = 2'd3} state_t;
  localparam logic [1:0] REQ_M0R = 2'd0;
  localparam logic [1:0] REQ_M1R = 2'd1;
  localparam logic [1:0] REQ_M1W = 2'd2;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return i >= REQ_M1W ? REQ_M0R : i + 2'd1;
  endfunction
endpackage

// File: rtl/axi_rd_wr_arbiter_if.sv
// axi_rd_if / axi_wr_if: AXI4 read (AR+R) and write (AW+W+B) channel bundles
interface axi_rd_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64, parameter int ID_W = 4);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  modport master (output arvalid, araddr, arid, arlen, arsize, arburst, rready,
                  input arready, rvalid, rdata, rid, rresp, rlast);
  modport slave  (input arvalid, araddr, arid, arlen, arsize, arburst, rready,
                  output arready, rvalid, rdata, rid, rresp, rlast);
endinterface

interface axi_wr_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64, parameter int ID_W = 4);
  logic                awvalid, awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid, bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  modport master (output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
                  input awready, wready, bvalid, bid, bresp);
  modport slave  (input awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
                  output awready, wready, bvalid, bid, bresp);
endinterface

// File: rtl/axi_rd_wr_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker, searching from the requester after last
module rr_pick3
  import axi_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);
  logic [3:0] r;
  logic [1:0] c1, c2, c3;
  always_comb begin
    r = {1'b0, req};
    c1 = rr_next(last);
    c2 = rr_next(c1);
    c3 = rr_next(c2);
    valid = |req;
    idx = r[c1] ? c1 : r[c2] ? c2 : c3;
  end
endmodule

// File: rtl/axi_rd_wr_arbiter.sv
// axi_rd_wr_arbiter: one-transaction-at-a-time sharing of an AXI4 SRAM port between IFU reads and LSU reads/writes
module axi_rd_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       aclk,
  input  logic       aresetn,
  axi_rd_if.slave    m0_rd,
  axi_rd_if.slave    m1_rd,
  axi_wr_if.slave    m1_wr,
  axi_rd_if.master   s_rd,
  axi_wr_if.master   s_wr,
  output logic [1:0] grant,
  output logic       err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nxt, pick_state;
  logic [1:0] ptr, pick_idx;
  logic pick_valid, ar_done, aw_done, rd0, rd1, wr, r_end, b_end;
  logic [CW-1:0] busy_cnt;

  rr_pick3 u_pick (
    .req   ({m1_wr.awvalid, m1_rd.arvalid, m0_rd.arvalid}),
    .last  (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rd0 = state == RD0;
  assign rd1 = state == RD1;
  assign wr = state == WR;
  assign r_end = s_rd.rvalid & s_rd.rready & s_rd.rlast;
  assign b_end = s_wr.bvalid & s_wr.bready;
  assign grant = state;

  always_comb begin
    pick_state = pick_idx == REQ_M0R ? RD0 : pick_idx == REQ_M1R ? RD1 : WR;
    nxt = state;
    if (state == IDLE) nxt = pick_valid ? pick_state : IDLE;
    else if (wr ? b_end : r_end) nxt = IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= nxt;

  // Per-grant bookkeeping is cleared while idle, so every grant starts fresh
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ptr <= REQ_M1W;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      busy_cnt <= '0;
      err_timeout <= 1'b0;
    end else if (state == IDLE) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      busy_cnt <= '0;
      if (pick_valid) ptr <= pick_idx;
    end else begin
      ar_done <= ar_done | (s_rd.arvalid & s_rd.arready);
      aw_done <= aw_done | (s_wr.awvalid & s_wr.awready);
      if (busy_cnt != CW'(TIMEOUT)) busy_cnt <= busy_cnt + CW'(1);
      if (busy_cnt == CW'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end

  assign s_rd.arvalid = (rd0 & m0_rd.arvalid | rd1 & m1_rd.arvalid) & ~ar_done;
  assign {s_rd.araddr, s_rd.arid, s_rd.arlen, s_rd.arsize, s_rd.arburst} =
    rd0 ? {m0_rd.araddr, m0_rd.arid, m0_rd.arlen, m0_rd.arsize, m0_rd.arburst} :
    rd1 ? {m1_rd.araddr, m1_rd.arid, m1_rd.arlen, m1_rd.arsize, m1_rd.arburst} : '0;
  assign s_rd.rready = rd0 & m0_rd.rready | rd1 & m1_rd.rready;
  assign m0_rd.arready = rd0 & s_rd.arready & ~ar_done;
  assign m0_rd.rvalid = rd0 & s_rd.rvalid;
  assign {m0_rd.rdata, m0_rd.rid, m0_rd.rresp, m0_rd.rlast} =
    rd0 ? {s_rd.rdata, s_rd.rid, s_rd.rresp, s_rd.rlast} : '0;
  assign m1_rd.arready = rd1 & s_rd.arready & ~ar_done;
  assign m1_rd.rvalid = rd1 & s_rd.rvalid;
  assign {m1_rd.rdata, m1_rd.rid, m1_rd.rresp, m1_rd.rlast} =
    rd1 ? {s_rd.rdata, s_rd.rid, s_rd.rresp, s_rd.rlast} : '0;

  assign s_wr.awvalid = wr & m1_wr.awvalid & ~aw_done;
  assign {s_wr.awaddr, s_wr.awid, s_wr.awlen, s_wr.awsize, s_wr.awburst} =
    wr ? {m1_wr.awaddr, m1_wr.awid, m1_wr.awlen, m1_wr.awsize, m1_wr.awburst} : '0;
  assign m1_wr.awready = wr & s_wr.awready & ~aw_done;
  assign s_wr.wvalid = wr & m1_wr.wvalid;
  assign {s_wr.wdata, s_wr.wstrb, s_wr.wlast} = wr ? {m1_wr.wdata, m1_wr.wstrb, m1_wr.wlast} : '0;
  assign m1_wr.wready = wr & s_wr.wready;
  assign m1_wr.bvalid = wr & s_wr.bvalid;
  assign {m1_wr.bid, m1_wr.bresp} = wr ? {s_wr.bid, s_wr.bresp} : '0;
  assign s_wr.bready = wr & m1_wr.bready;
endmodule

// File: tb/tb_axi_rd_wr_arbiter.sv
// tb_axi_rd_wr_arbiter: directed vectors and sequences for the SRAM port arbiter
module tb_axi_rd_wr_arbiter;
  logic aclk = 1'b0, aresetn = 1'b1;
  logic [1:0] grant;
  logic err;
  int checks = 0, errors = 0;

  axi_rd_if m0 ();
  axi_rd_if m1r ();
  axi_rd_if sr ();
  axi_wr_if m1w ();
  axi_wr_if sw ();

  axi_rd_wr_arbiter #(.TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .m0_rd(m0), .m1_rd(m1r), .m1_wr(m1w),
    .s_rd(sr), .s_wr(sw), .grant(grant), .err_timeout(err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic m0r, m1r, m1w;
    logic [1:0] gnt;
    logic sar, saw;
  } vec_t;
  vec_t tbl [12];
  logic [63:0] wmem [2];
  logic [63:0] wexp [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    {m0.arvalid, m0.araddr, m0.arid, m0.arlen, m0.arsize, m0.arburst, m0.rready} = '0;
    {m1r.arvalid, m1r.araddr, m1r.arid, m1r.arlen, m1r.arsize, m1r.arburst, m1r.rready} = '0;
    {m1w.awvalid, m1w.awaddr, m1w.awid, m1w.awlen, m1w.awsize, m1w.awburst} = '0;
    {m1w.wvalid, m1w.wdata, m1w.wstrb, m1w.wlast, m1w.bready} = '0;
    {sr.arready, sr.rvalid, sr.rdata, sr.rid, sr.rresp, sr.rlast} = '0;
    {sw.awready, sw.wready, sw.bvalid, sw.bid, sw.bresp} = '0;
  endtask

  task automatic all_outs(input string name);
    chk(name, {grant, err, m0.arready, m0.rvalid, m1r.arready, m1r.rvalid, m1w.awready, m1w.wready,
               m1w.bvalid, sr.arvalid, sr.rready, sw.awvalid, sw.wvalid, sw.bready}, 64'd0);
  endtask

  task automatic serve(input string name);
    {sr.arready, sr.rvalid, sr.rlast, m0.rready, m1r.rready} = '1;
    {sw.awready, sw.wready, sw.bvalid, m1w.bready, m1w.wlast} = '1;
    @(negedge aclk);
    chk({name, "_idle"}, grant, 2'd0);
    idle_all();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    wexp[0] = 64'h1122_3344_5566_7788;
    wexp[1] = 64'h99AA_BBCC_DDEE_FF00;
    idle_all();
    #1 aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    all_outs("reset_outs");
    aresetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      m0.arvalid = tbl[i].m0r;
      m1r.arvalid = tbl[i].m1r;
      m1w.awvalid = tbl[i].m1w;
      m1w.wvalid = tbl[i].m1w;
      @(negedge aclk);
      chk($sformatf("v%0d_grant", i), grant, tbl[i].gnt);
      chk($sformatf("v%0d_s_arvalid", i), sr.arvalid, tbl[i].sar);
      chk($sformatf("v%0d_s_awvalid", i), sw.awvalid, tbl[i].saw);
      if (tbl[i].gnt != 2'd0) serve($sformatf("v%0d", i));
      idle_all();
    end

    m0.arvalid = 1'b1;
    m0.araddr = 32'h8000_0000;
    m0.arlen = 8'd3;
    m0.arid = 4'h5;
    @(negedge aclk);
    chk("a_grant", grant, 2'd1);
    chk("a_s_araddr", sr.araddr, 64'h8000_0000);
    chk("a_s_arlen", sr.arlen, 64'd3);
    chk("a_s_arvalid", sr.arvalid, 1'b1);
    sr.arready = 1'b1;
    @(negedge aclk);
    chk("a_ar_gated", {sr.arvalid, m0.arready}, 2'b00);
    for (int b = 0; b < 4; b++) begin
      sr.rvalid = 1'b1;
      sr.rdata = 64'hA0 + 64'(b);
      sr.rid = 4'h5;
      sr.rlast = b == 3;
      m0.rready = 1'b1;
      #1;
      chk($sformatf("a_beat%0d_r", b), {m0.rvalid, m0.rlast, m0.rid, m1r.rvalid, sr.rready, sr.arvalid},
          {1'b1, b == 3, 4'h5, 1'b0, 1'b1, 1'b0});
      chk($sformatf("a_beat%0d_data", b), m0.rdata, 64'hA0 + 64'(b));
      @(negedge aclk);
    end
    chk("a_idle", grant, 2'd0);
    idle_all();
    m1r.arvalid = 1'b1;
    @(negedge aclk);
    chk("a_next_grant", grant, 2'd2);
    serve("a2");

    m1w.awvalid = 1'b1;
    m1w.awaddr = 32'h100;
    m1w.awlen = 8'd1;
    m1w.awid = 4'h3;
    m1w.wvalid = 1'b1;
    m1w.wdata = wexp[0];
    m1w.wstrb = 8'hFF;
    m1w.bready = 1'b1;
    m1r.arvalid = 1'b1;
    m1r.araddr = 32'h100;
    m1r.arlen = 8'd1;
    {sw.awready, sw.wready} = 2'b11;
    @(negedge aclk);
    chk("b_grant_wr", grant, 2'd3);
    chk("b_w0", {sw.awvalid, sw.wvalid, sw.wstrb, sw.wlast, sr.arvalid}, {1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
    wmem[0] = sw.wdata;
    @(negedge aclk);
    m1w.wdata = wexp[1];
    m1w.wlast = 1'b1;
    #1;
    chk("b_w1", {sw.awvalid, sw.wvalid, sw.wlast, sr.arvalid}, 4'b0110);
    wmem[1] = sw.wdata;
    @(negedge aclk);
    m1w.wvalid = 1'b0;
    sw.bvalid = 1'b1;
    sw.bid = 4'h3;
    #1;
    chk("b_bresp", {m1w.bvalid, m1w.bid, sr.arvalid}, {1'b1, 4'h3, 1'b0});
    @(negedge aclk);
    chk("b_idle", grant, 2'd0);
    {m1w.awvalid, sw.bvalid} = 2'b00;
    @(negedge aclk);
    chk("b_grant_rd", grant, 2'd2);
    chk("b_s_araddr", sr.araddr, 64'h100);
    sr.arready = 1'b1;
    @(negedge aclk);
    for (int b = 0; b < 2; b++) begin
      sr.rvalid = 1'b1;
      sr.rdata = wmem[b];
      sr.rlast = b == 1;
      m1r.rready = 1'b1;
      #1;
      chk($sformatf("b_rd%0d", b), m1r.rdata, wexp[b]);
      @(negedge aclk);
    end
    chk("b_rd_idle", grant, 2'd0);
    idle_all();

    m0.arvalid = 1'b1;
    m0.arlen = 8'd3;
    sr.arready = 1'b1;
    @(negedge aclk);
    chk("c_grant", grant, 2'd1);
    @(negedge aclk);
    m0.arvalid = 1'b0;
    {sr.rvalid, m0.rready} = 2'b11;
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    all_outs("c_reset_outs");
    idle_all();
    @(negedge aclk);
    aresetn = 1'b1;
    m1r.arvalid = 1'b1;
    @(negedge aclk);
    chk("c_grant_after", grant, 2'd2);
    serve("c");

    m0.arvalid = 1'b1;
    sr.arready = 1'b1;
    @(negedge aclk);
    chk("d_grant", grant, 2'd1);
    @(negedge aclk);
    idle_all();
    for (int k = 2; k <= 15; k++) @(negedge aclk);
    chk("d_err_before", err, 1'b0);
    @(negedge aclk);
    chk("d_err_at16", err, 1'b1);
    {sr.rvalid, sr.rlast, m0.rready} = 3'b111;
    @(negedge aclk);
    chk("d_done", {grant, err}, {2'd0, 1'b1});
    idle_all();
    @(negedge aclk);
    chk("d_sticky", err, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("d_reset_clears", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
